instruction_loader: RTL

Controller that sequences writes into the fetch-stage instruction memory. It accepts a byte stream from the debug/UART receiver, assembles four bytes MSB-first into 32-bit instructions, and drives the memory's write port at consecutive word addresses. It terminates on a halt word or when memory capacity is exhausted. While loading it holds `o_busy` so the pipeline keeps the PC/fetch stage stalled.

---
 rtl/instruction_loader_pkg.sv | 22 ++
 rtl/instruction_loader_if.sv | 29 ++
 rtl/instruction_loader_word_assembler.sv | 34 +++
 rtl/instruction_loader.sv | 101 ++++++++++
 4 files changed

// File: rtl/instruction_loader_pkg.sv
// Shared definitions for the instruction loader: state encoding, halt marker and defaults.
package instruction_loader_pkg;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_RECV  = 3'd1;
   localparam logic [2:0] ST_WRITE = 3'd2;
   localparam logic [2:0] ST_DONE  = 3'd3;
   localparam logic [2:0] ST_ERROR = 3'd4;

   typedef enum logic [2:0] {
      S_IDLE  = ST_IDLE,
      S_RECV  = ST_RECV,
      S_WRITE = ST_WRITE,
      S_DONE  = ST_DONE,
      S_ERROR = ST_ERROR
   } state_e;

   localparam logic [31:0] HALT_WORD         = 32'hFFFF_FFFF;
   localparam int unsigned DEFAULT_ADDR_STEP = 4;
   localparam int unsigned BYTE_W            = 8;

endpackage

// File: rtl/instruction_loader_if.sv
// Byte-stream input and memory write port of the instruction loader.
interface instruction_loader_if #(
   parameter int unsigned NB_ADDR     = 32,
   parameter int unsigned NB_INST     = 32,
   parameter int unsigned NB_ROM_SIZE = 10
);
   logic                   i_start;
   logic [7:0]             i_rx_data;
   logic                   i_rx_valid;
   logic                   o_mem_write;
   logic [NB_ADDR-1:0]     o_mem_address;
   logic [NB_INST-1:0]     o_mem_instruction;
   logic                   o_busy;
   logic                   o_done;
   logic                   o_error;
   logic [NB_ROM_SIZE:0]   o_count;

   modport master (
      output i_start, i_rx_data, i_rx_valid,
      input  o_mem_write, o_mem_address, o_mem_instruction,
             o_busy, o_done, o_error, o_count
   );

   modport slave (
      input  i_start, i_rx_data, i_rx_valid,
      output o_mem_write, o_mem_address, o_mem_instruction,
             o_busy, o_done, o_error, o_count
   );
endinterface

// File: rtl/instruction_loader_word_assembler.sv
// Shifts received bytes MSB-first into a word and flags the byte that completes it.
module instruction_loader_word_assembler
   import instruction_loader_pkg::*;
#(
   parameter int unsigned NB_INST = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               clear,
   input  logic               shift,
   input  logic [7:0]         data,
   output logic [NB_INST-1:0] word,
   output logic               word_complete_c
);

   logic [1:0] byte_cnt;

   // The 2-bit counter wraps to 0 on the 4th byte, so the next word starts clean.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         word     <= '0;
         byte_cnt <= 2'd0;
      end else if (clear) begin
         word     <= '0;
         byte_cnt <= 2'd0;
      end else if (shift) begin
         word     <= {word[NB_INST-BYTE_W-1:0], data};
         byte_cnt <= byte_cnt + 2'd1;
      end
   end

   assign word_complete_c = shift && (byte_cnt == 2'd3);

endmodule

// File: rtl/instruction_loader.sv
// Loads a byte stream into instruction memory word by word, stopping on a halt word or at capacity.
module instruction_loader
   import instruction_loader_pkg::*;
#(
   parameter int unsigned NB_ADDR     = 32,
   parameter int unsigned NB_INST     = 32,
   parameter int unsigned NB_ROM_SIZE = 10,
   parameter int unsigned ADDR_STEP   = DEFAULT_ADDR_STEP
) (
   input logic                 i_clk,
   input logic                 i_reset,
   instruction_loader_if.slave bus
);

   localparam int unsigned        NB_CNT    = NB_ROM_SIZE + 1;
   localparam int unsigned        TAM       = 32'(1) << NB_ROM_SIZE;
   localparam logic [NB_ADDR-1:0] LAST_ADDR = NB_ADDR'(TAM - ADDR_STEP);
   localparam logic [NB_ADDR-1:0] STEP      = NB_ADDR'(ADDR_STEP);

   state_e              state, state_next;
   logic [NB_ADDR-1:0]  addr, addr_next;
   logic [NB_CNT-1:0]   count, count_next;
   logic                mem_write, busy, done, error;
   logic                clear_c, shift_c, word_complete_c;
   logic [NB_INST-1:0]  word;

   // Bytes are accepted in RECV and in the WRITE cycle; a start pulse drops a coincident byte.
   assign shift_c = bus.i_rx_valid && !bus.i_start &&
                    ((state == S_RECV) || (state == S_WRITE));

   instruction_loader_word_assembler #(
      .NB_INST (NB_INST)
   ) u_word_assembler (
      .clk             (i_clk),
      .rst_n           (i_reset),
      .clear           (clear_c),
      .shift           (shift_c),
      .data            (bus.i_rx_data),
      .word            (word),
      .word_complete_c (word_complete_c)
   );

   // Next-state, address and count logic; start restarts the load from any state.
   always_comb begin
      state_next = state;
      addr_next  = addr;
      count_next = count;
      clear_c    = 1'b0;
      if (bus.i_start) begin
         state_next = S_RECV;
         addr_next  = '0;
         count_next = '0;
         clear_c    = 1'b1;
      end else begin
         case (state)
            S_RECV: begin
               if (word_complete_c) begin
                  state_next = (addr <= LAST_ADDR) ? S_WRITE : S_ERROR;
               end
            end
            S_WRITE: begin
               addr_next  = addr + STEP;
               count_next = count + NB_CNT'(1);
               state_next = (word == NB_INST'(HALT_WORD)) ? S_DONE : S_RECV;
            end
            S_IDLE, S_DONE, S_ERROR: state_next = state;
            default:                 state_next = S_IDLE;
         endcase
      end
   end

   // State, counters and flags all register from the next-state decision.
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         state     <= S_IDLE;
         addr      <= '0;
         count     <= '0;
         mem_write <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         error     <= 1'b0;
      end else begin
         state     <= state_next;
         addr      <= addr_next;
         count     <= count_next;
         mem_write <= (state_next == S_WRITE);
         busy      <= (state_next == S_RECV) || (state_next == S_WRITE);
         done      <= (state_next == S_DONE);
         error     <= (state_next == S_ERROR);
      end
   end

   assign bus.o_mem_write       = mem_write;
   assign bus.o_mem_address     = addr;
   assign bus.o_mem_instruction = word;
   assign bus.o_busy            = busy;
   assign bus.o_done            = done;
   assign bus.o_error           = error;
   assign bus.o_count           = count;

endmodule
